// File: rtl/viterbi_frame_sequencer_if.sv
// Symbol stream handshake between the encoder-symbol source and the
// Viterbi frame sequencer. The source drives valid/data; the sequencer
// answers with ready.
interface viterbi_frame_sequencer_if;
  logic       sym_valid;
  logic [2:0] sym_in;
  logic       sym_ready;

  modport master (output sym_valid, output sym_in, input sym_ready);
  modport slave  (input sym_valid, input sym_in, output sym_ready);
endinterface

// File: rtl/viterbi_frame_sequencer.sv
// Front-end controller for the Viterbi decoder: accepts encoder symbols,
// presents them to the branch-distance unit with an ACS strobe, appends the
// zero termination symbols, runs the traceback window and pulses done.
module viterbi_frame_sequencer #(
  parameter int FRAME_LEN = 16,
  parameter int TAIL_LEN  = 2,
  parameter int TB_LEN    = 18,
  parameter int CNT_W     = 6
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     start,
  viterbi_frame_sequencer_if.slave sym,
  output logic                     Y2N,
  output logic                     Y1N,
  output logic                     Y0N,
  output logic                     acs_en,
  output logic                     frame_first,
  output logic [CNT_W-1:0]         sym_idx,
  output logic                     tb_en,
  output logic                     tb_first,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_TRACE,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(FRAME_LEN + TAIL_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_TB   = CNT_W'(TB_LEN - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_symCnt;
  logic [CNT_W-1:0] r_tbCnt;
  logic [2:0]       r_y;
  logic             r_acsEn;
  logic             r_frameFirst;
  logic [CNT_W-1:0] r_symIdx;
  logic             r_tbEn;
  logic             r_tbFirst;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_symCnt;
  logic [CNT_W-1:0] w_tbCnt;
  logic [2:0]       w_y;
  logic             w_acsEn;
  logic             w_frameFirst;
  logic [CNT_W-1:0] w_symIdx;
  logic             w_tbEn;
  logic             w_tbFirst;
  logic             w_busy;
  logic             w_done;
  logic             w_accept;

  // Ready is the only unregistered output: it follows the state directly.
  assign sym.sym_ready = (r_state == S_LOAD);
  assign w_accept      = (r_state == S_LOAD) && sym.sym_valid;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!res) r_state <= S_IDLE;
    else      r_state <= w_nextState;
  end

  // Next-state decode; the last data symbol skips FLUSH when there is no tail.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nextState = S_LOAD;
      S_LOAD:  if (w_accept && (r_symCnt == LAST_DATA))
                 w_nextState = (TAIL_LEN > 0) ? S_FLUSH : S_TRACE;
      S_FLUSH: if (r_symCnt == LAST_TAIL) w_nextState = S_TRACE;
      S_TRACE: if (r_tbCnt == LAST_TB) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Next values of counters and outputs; Y and sym_idx hold when no symbol is issued.
  always_comb begin
    w_symCnt     = r_symCnt;
    w_tbCnt      = r_tbCnt;
    w_y          = r_y;
    w_acsEn      = 1'b0;
    w_frameFirst = 1'b0;
    w_symIdx     = r_symIdx;
    w_tbEn       = 1'b0;
    w_tbFirst    = 1'b0;
    w_busy       = (w_nextState != S_IDLE);
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_symCnt = '0;
          w_tbCnt  = '0;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_y          = sym.sym_in;
          w_acsEn      = 1'b1;
          w_symIdx     = r_symCnt;
          w_frameFirst = (r_symCnt == '0);
          w_symCnt     = r_symCnt + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        w_y      = 3'b000;
        w_acsEn  = 1'b1;
        w_symIdx = r_symCnt;
        w_symCnt = r_symCnt + CNT_W'(1);
      end
      S_TRACE: begin
        w_tbEn    = 1'b1;
        w_tbFirst = (r_tbCnt == '0);
        w_tbCnt   = r_tbCnt + CNT_W'(1);
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_symCnt = '0;
        w_tbCnt  = '0;
      end
    endcase
  end

  // Output and counter registers; reset clears everything and drops any frame.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_symCnt     <= '0;
      r_tbCnt      <= '0;
      r_y          <= 3'b000;
      r_acsEn      <= 1'b0;
      r_frameFirst <= 1'b0;
      r_symIdx     <= '0;
      r_tbEn       <= 1'b0;
      r_tbFirst    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_symCnt     <= w_symCnt;
      r_tbCnt      <= w_tbCnt;
      r_y          <= w_y;
      r_acsEn      <= w_acsEn;
      r_frameFirst <= w_frameFirst;
      r_symIdx     <= w_symIdx;
      r_tbEn       <= w_tbEn;
      r_tbFirst    <= w_tbFirst;
      r_busy       <= w_busy;
      r_done       <= w_done;
    end
  end

  assign Y2N         = r_y[2];
  assign Y1N         = r_y[1];
  assign Y0N         = r_y[0];
  assign acs_en      = r_acsEn;
  assign frame_first = r_frameFirst;
  assign sym_idx     = r_symIdx;
  assign tb_en       = r_tbEn;
  assign tb_first    = r_tbFirst;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_viterbi_frame_sequencer.sv
// Directed bench for viterbi_frame_sequencer: a cycle table for reset, a
// basic frame, a back-to-back frame with stalls, then hand-written
// sequences for ignored starts, mid-frame reset and the no-tail variant.
module tb_viterbi_frame_sequencer;

  typedef struct {
    logic       res;
    logic       start;
    logic       valid;
    logic [2:0] sym;
    logic       rdy;
    logic [2:0] y;
    logic       acs;
    logic       ff;
    logic [5:0] idx;
    logic       tb;
    logic       tbf;
    logic       busy;
    logic       done;
  } vec_t;

  logic clk = 1'b0;
  logic res;
  logic startA;
  logic startB;

  logic       aY2, aY1, aY0, aAcs, aFf, aTb, aTbf, aBusy, aDone;
  logic [5:0] aIdx;
  logic       bY2, bY1, bY0, bAcs, bFf, bTb, bTbf, bBusy, bDone;
  logic [5:0] bIdx;

  int checks = 0;
  int errors = 0;

  vec_t vecs [34];

  viterbi_frame_sequencer_if ifA ();
  viterbi_frame_sequencer_if ifB ();

  // Clock generation.
  always #5 clk = ~clk;

  // Main DUT with a two-symbol tail.
  viterbi_frame_sequencer #(.FRAME_LEN(4), .TAIL_LEN(2), .TB_LEN(6), .CNT_W(6)) dutA (
    .clk(clk), .res(res), .start(startA), .sym(ifA.slave),
    .Y2N(aY2), .Y1N(aY1), .Y0N(aY0), .acs_en(aAcs), .frame_first(aFf),
    .sym_idx(aIdx), .tb_en(aTb), .tb_first(aTbf), .busy(aBusy), .done(aDone)
  );

  // Variant without termination symbols.
  viterbi_frame_sequencer #(.FRAME_LEN(4), .TAIL_LEN(0), .TB_LEN(6), .CNT_W(6)) dutB (
    .clk(clk), .res(res), .start(startB), .sym(ifB.slave),
    .Y2N(bY2), .Y1N(bY1), .Y0N(bY0), .acs_en(bAcs), .frame_first(bFf),
    .sym_idx(bIdx), .tb_en(bTb), .tb_first(bTbf), .busy(bBusy), .done(bDone)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    res           = v.res;
    startA        = v.start;
    ifA.sym_valid = v.valid;
    ifA.sym_in    = v.sym;
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic vl, input logic [2:0] sy,
                              input logic rd, input logic [2:0] y, input logic acs, input logic ff,
                              input logic [5:0] idx, input logic tb, input logic tbf,
                              input logic busy, input logic done);
    vec_t v;
    v.res = r; v.start = s; v.valid = vl; v.sym = sy; v.rdy = rd; v.y = y; v.acs = acs;
    v.ff = ff; v.idx = idx; v.tb = tb; v.tbf = tbf; v.busy = busy; v.done = done;
    return v;
  endfunction

  // One frame on DUT A with optional start pokes while busy; checks totals.
  task automatic runFrameA(input bit poke, input string tag);
    int nAcs = 0;
    int nTb = 0;
    int nDone = 0;
    int nFf = 0;
    int nTbf = 0;
    @(negedge clk);
    startA = 1'b1; ifA.sym_valid = 1'b1; ifA.sym_in = 3'd6;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (aAcs) nAcs++;
      if (aTb) nTb++;
      if (aDone) nDone++;
      if (aFf) nFf++;
      if (aTbf) nTbf++;
      startA = poke && (ifA.sym_ready || aTb);
    end
    startA = 1'b0;
    checkOutput({tag, ".acsCount"}, nAcs, 6);
    checkOutput({tag, ".tbCount"}, nTb, 6);
    checkOutput({tag, ".doneCount"}, nDone, 1);
    checkOutput({tag, ".frameFirstCount"}, nFf, 1);
    checkOutput({tag, ".tbFirstCount"}, nTbf, 1);
    checkOutput({tag, ".busyEnd"}, int'(aBusy), 0);
  endtask

  initial begin
    vec_t v;
    int waitCnt;
    int nDone;
    int nAcs;
    int nTb;
    int nZeroY;
    int maxIdx;
    int gapTb;
    logic prevAcs;
    logic [2:0] symsB [4];

    vecs[0]  = mk(0,1,1,5, 0,0,0,0,0, 0,0,0,0);
    vecs[1]  = mk(0,1,1,5, 0,0,0,0,0, 0,0,0,0);
    vecs[2]  = mk(1,1,1,5, 0,0,0,0,0, 0,0,0,0);
    vecs[3]  = mk(1,0,1,5, 1,0,0,0,0, 0,0,1,0);
    vecs[4]  = mk(1,0,1,3, 1,5,1,1,0, 0,0,1,0);
    vecs[5]  = mk(1,0,1,7, 1,3,1,0,1, 0,0,1,0);
    vecs[6]  = mk(1,0,1,1, 1,7,1,0,2, 0,0,1,0);
    vecs[7]  = mk(1,0,0,0, 0,1,1,0,3, 0,0,1,0);
    vecs[8]  = mk(1,0,0,0, 0,0,1,0,4, 0,0,1,0);
    vecs[9]  = mk(1,0,0,0, 0,0,1,0,5, 0,0,1,0);
    vecs[10] = mk(1,0,0,0, 0,0,0,0,5, 1,1,1,0);
    vecs[11] = mk(1,0,0,0, 0,0,0,0,5, 1,0,1,0);
    vecs[12] = mk(1,0,0,0, 0,0,0,0,5, 1,0,1,0);
    vecs[13] = mk(1,0,0,0, 0,0,0,0,5, 1,0,1,0);
    vecs[14] = mk(1,0,0,0, 0,0,0,0,5, 1,0,1,0);
    vecs[15] = mk(1,0,0,0, 0,0,0,0,5, 1,0,1,0);
    vecs[16] = mk(1,1,0,0, 0,0,0,0,5, 0,0,0,1);
    vecs[17] = mk(1,0,1,5, 1,0,0,0,5, 0,0,1,0);
    vecs[18] = mk(1,0,0,3, 1,5,1,1,0, 0,0,1,0);
    vecs[19] = mk(1,0,0,3, 1,5,0,0,0, 0,0,1,0);
    vecs[20] = mk(1,0,1,3, 1,5,0,0,0, 0,0,1,0);
    vecs[21] = mk(1,0,1,7, 1,3,1,0,1, 0,0,1,0);
    vecs[22] = mk(1,0,0,1, 1,7,1,0,2, 0,0,1,0);
    vecs[23] = mk(1,0,1,1, 1,7,0,0,2, 0,0,1,0);
    vecs[24] = mk(1,0,1,6, 0,1,1,0,3, 0,0,1,0);
    vecs[25] = mk(1,0,0,0, 0,0,1,0,4, 0,0,1,0);
    vecs[26] = mk(1,0,0,0, 0,0,1,0,5, 0,0,1,0);
    vecs[27] = mk(1,0,0,0, 0,0,0,0,5, 1,1,1,0);
    vecs[28] = mk(1,0,0,0, 0,0,0,0,5, 1,0,1,0);
    vecs[29] = mk(1,0,0,0, 0,0,0,0,5, 1,0,1,0);
    vecs[30] = mk(1,0,0,0, 0,0,0,0,5, 1,0,1,0);
    vecs[31] = mk(1,0,0,0, 0,0,0,0,5, 1,0,1,0);
    vecs[32] = mk(1,0,0,0, 0,0,0,0,5, 1,0,1,0);
    vecs[33] = mk(1,0,0,0, 0,0,0,0,5, 0,0,0,1);

    res = 1'b0; startA = 1'b1; startB = 1'b0;
    ifA.sym_valid = 1'b1; ifA.sym_in = 3'd5;
    ifB.sym_valid = 1'b0; ifB.sym_in = 3'd0;

    // Table: reset, basic frame, back-to-back frame with stalls.
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      v = vecs[i];
      applyStimulus(v);
      #1;
      checkOutput($sformatf("v%0d.ready", i), int'(ifA.sym_ready), int'(v.rdy));
      checkOutput($sformatf("v%0d.y", i), int'({aY2, aY1, aY0}), int'(v.y));
      checkOutput($sformatf("v%0d.acs", i), int'(aAcs), int'(v.acs));
      checkOutput($sformatf("v%0d.frameFirst", i), int'(aFf), int'(v.ff));
      if (v.acs) checkOutput($sformatf("v%0d.symIdx", i), int'(aIdx), int'(v.idx));
      checkOutput($sformatf("v%0d.tb", i), int'(aTb), int'(v.tb));
      checkOutput($sformatf("v%0d.tbFirst", i), int'(aTbf), int'(v.tbf));
      checkOutput($sformatf("v%0d.busy", i), int'(aBusy), int'(v.busy));
      checkOutput($sformatf("v%0d.done", i), int'(aDone), int'(v.done));
    end

    // Starts pulsed during LOAD and TRACE must not queue a second frame.
    @(negedge clk);
    startA = 1'b0; ifA.sym_valid = 1'b0;
    runFrameA(1'b1, "ignoreStart");

    // Reset during TRACE abandons the frame without done.
    @(negedge clk);
    startA = 1'b1; ifA.sym_valid = 1'b1; ifA.sym_in = 3'd2;
    @(negedge clk);
    startA = 1'b0;
    waitCnt = 0;
    #1;
    while (!aTb && waitCnt < 30) begin
      @(negedge clk);
      #1;
      waitCnt++;
    end
    checkOutput("midReset.reachedTrace", int'(aTb), 1);
    res = 1'b0;
    @(negedge clk);
    #1;
    res = 1'b1;
    checkOutput("midReset.outputs",
                int'({aY2, aY1, aY0, aAcs, aFf, aTb, aTbf, aBusy, aDone, ifA.sym_ready}), 0);
    checkOutput("midReset.symIdx", int'(aIdx), 0);
    nDone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (aDone) nDone++;
    end
    checkOutput("midReset.noDone", nDone, 0);
    runFrameA(1'b0, "afterReset");

    // No-tail variant: four ACS strobes, traceback right after the last one.
    symsB[0] = 3'd5; symsB[1] = 3'd3; symsB[2] = 3'd7; symsB[3] = 3'd1;
    @(negedge clk);
    startB = 1'b1; ifB.sym_valid = 1'b1; ifB.sym_in = symsB[0];
    nAcs = 0; nTb = 0; nDone = 0; nZeroY = 0; maxIdx = 0; gapTb = -1; prevAcs = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      startB = 1'b0;
      #1;
      if (bAcs) begin
        nAcs++;
        if ({bY2, bY1, bY0} == 3'd0) nZeroY++;
        if (int'(bIdx) > maxIdx) maxIdx = int'(bIdx);
      end
      if (prevAcs && !bAcs && gapTb < 0) gapTb = int'(bTb);
      prevAcs = bAcs;
      if (bTb) nTb++;
      if (bDone) nDone++;
      ifB.sym_in = symsB[nAcs % 4];
    end
    checkOutput("noTail.acsCount", nAcs, 4);
    checkOutput("noTail.zeroSymbols", nZeroY, 0);
    checkOutput("noTail.maxIdx", maxIdx, 3);
    checkOutput("noTail.tbAfterLastAcs", gapTb, 1);
    checkOutput("noTail.tbCount", nTb, 6);
    checkOutput("noTail.doneCount", nDone, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
